// File: rtl/rom_fetch_ctrl_if.sv
`timescale 1ns/1ps
// ROM-side bus between the fetch sequencer (master) and the 16-bit ROM interface (slave).
interface rom_fetch_ctrl_if;
  logic        o_rd_rom;
  logic        o_wr_rom;
  logic [6:0]  o_addr_rom;
  logic [7:0]  o_wordcnt_rom;
  logic        i_fifo_full_rom;
  logic        i_done_rom;
  logic [15:0] i_data_rom_16bits;

  modport master (
    output o_rd_rom, o_wr_rom, o_addr_rom, o_wordcnt_rom,
    input  i_fifo_full_rom, i_done_rom, i_data_rom_16bits
  );

  modport slave (
    input  o_rd_rom, o_wr_rom, o_addr_rom, o_wordcnt_rom,
    output i_fifo_full_rom, i_done_rom, i_data_rom_16bits
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
`timescale 1ns/1ps
// Fetches WORDS consecutive ROM words and packs them (first word in MSBs) behind a valid/ack handshake.
// Define ROM_FETCH_TIMEOUT_EN to add a FETCH watchdog and the o_err pulse output.
module rom_fetch_ctrl #(
  parameter  int WORDS = 4,
  localparam int OUT_W = 16 * WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [6:0]        i_base_addr,
  rom_fetch_ctrl_if.master  rom,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_valid,
  input  logic              i_ack,
  output logic              o_busy
`ifdef ROM_FETCH_TIMEOUT_EN
  ,
  output logic              o_err
`endif
);

  localparam int CNT_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, PARK, FETCH, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         base_q, base_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic               rd_q, rd_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
`ifdef ROM_FETCH_TIMEOUT_EN
  logic [3:0]         wd_q, wd_d;
  logic               err_q, err_d;
`endif

  // Drops the oldest word off the top; also covers WORDS == 1 where no bits survive.
  function automatic logic [OUT_W-1:0] shift_in(input logic [OUT_W-1:0] acc,
                                                 input logic [15:0]      word);
    logic [OUT_W+15:0] cat;
    cat = {acc, word};
    return cat[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef ROM_FETCH_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef ROM_FETCH_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    rd_d    = rd_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef ROM_FETCH_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = PARK;
          base_d  = i_base_addr;
          cnt_d   = CNT_W'(WORDS);
          // Parking on the complement guarantees the interface sees an address change.
          addr_d  = i_base_addr ^ 7'h7F;
          wcnt_d  = 8'(WORDS);
          rd_d    = 1'b1;
          data_d  = '0;
        end
      end

      PARK: begin
        addr_d  = base_q;
        state_d = FETCH;
`ifdef ROM_FETCH_TIMEOUT_EN
        wd_d    = '0;
`endif
      end

      FETCH: begin
        if (rom.i_fifo_full_rom) begin
          data_d = shift_in(data_q, rom.i_data_rom_16bits);
          addr_d = addr_q + 7'd1;
          wcnt_d = wcnt_q - 8'd1;
          cnt_d  = cnt_q - CNT_W'(1);
`ifdef ROM_FETCH_TIMEOUT_EN
          wd_d   = '0;
`endif
          if (cnt_q == CNT_W'(1)) begin
            state_d = HOLD;
            valid_d = 1'b1;
            rd_d    = 1'b0;
            wcnt_d  = '0;
          end
        end
`ifdef ROM_FETCH_TIMEOUT_EN
        else if (wd_q == 4'd14) begin
          // Watchdog reaches 15: abandon the fetch and drop the partial operand.
          state_d = IDLE;
          rd_d    = 1'b0;
          wcnt_d  = '0;
          cnt_d   = '0;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 4'd1;
        end
`endif
      end

      HOLD: begin
        if (i_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rom.o_rd_rom      = rd_q;
  assign rom.o_wr_rom      = 1'b0;
  assign rom.o_addr_rom    = addr_q;
  assign rom.o_wordcnt_rom = wcnt_q;
  assign o_data            = data_q;
  assign o_valid           = valid_q;
  assign o_busy            = (state_q == PARK) || (state_q == FETCH);
`ifdef ROM_FETCH_TIMEOUT_EN
  assign o_err             = err_q;
`endif

  // i_done_rom carries no control; it only has to agree with the word count.
  property p_done_on_last;
    @(posedge clk) disable iff (!rst_n)
      (state_q == FETCH && rom.i_fifo_full_rom && cnt_q == CNT_W'(1)) |-> rom.i_done_rom;
  endproperty
  a_done_on_last: assert property (p_done_on_last);

endmodule
